writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
Writer-side front end for the CPU register file. It accepts single-cycle ALU results and multi-cycle load completions, and formats load data (byte/half extraction, sign/zero extension). It arbitrates between the two sources and drives the register-file write port (o_data, o_IR, o_load) with a one-cycle registered latency. It also exports the pending-load destination so decode can detect hazards.

Parameters:
XLEN, 32, datapath and instruction width. Fixed at 32; other values are unsupported.

Ports:
i_clk  in  1  system clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_alu_valid  in  1  ALU result available
i_alu_IR  in  32  instruction of ALU result; rd = [11:7]
i_alu_result  in  32  ALU result value
o_alu_ready  out  1  ALU result accepted this cycle when high with i_alu_valid
i_ld_valid  in  1  load issued to memory
i_ld_IR  in  32  load instruction; rd = [11:7], funct3 = [14:12]
i_ld_addr  in  2  byte offset (addr[1:0]) of the load
o_ld_ready  out  1  load issue accepted when high with i_ld_valid
i_mem_valid  in  1  memory read data valid (single-cycle pulse)
i_mem_rdata  in  32  aligned 32-bit memory word
o_data  out  32  write data to register file
o_IR  out  32  instruction carrying rd to register file
o_load  out  1  register-file write enable
o_pending  out  1  a load is outstanding
o_pending_rd  out  5  rd of the outstanding load; 0 when none
o_err  out  1  one-cycle pulse: illegal funct3 or misaligned load

Behaviour:
- Reset (async, i_rst_n=0):
  - state=S_IDLE.
  - o_load=0, o_data=0, o_IR=0, o_pending=0, o_pending_rd=0, o_err=0.
  - o_ld_ready=1, o_alu_ready=1.
- FSM states:
  - S_IDLE: i_ld_valid & o_ld_ready → latch IR and addr, go to S_WAIT_MEM.
  - S_WAIT_MEM: i_mem_valid → format and write, return to S_IDLE.
  - i_mem_valid in S_IDLE is ignored.
- o_ld_ready = (state==S_IDLE). Only one outstanding load.
- o_alu_ready is 0 when either holds:
  - state==S_WAIT_MEM & i_mem_valid (load wins the write port), or
  - state==S_WAIT_MEM & i_alu_IR[11:7]==pending rd & rd≠0 (WAW guard).
  - Otherwise o_alu_ready=1.
- Output register, updated every cycle:
  - Load completion: o_data=formatted, o_IR=latched load IR, o_load=1.
  - Else ALU accept: o_data=i_alu_result, o_IR=i_alu_IR, o_load=1.
  - Else: o_load=0; o_data and o_IR hold their values.
- rd=0: the write is consumed normally but o_load is forced to 0.
- Latency: accept cycle N → o_load high in cycle N+1, for exactly one cycle per write.
- Load formatting (off = latched addr[1:0]):
  - 000 LB: sign-extend byte[off].
  - 001 LH: sign-extend half[off[1]].
  - 010 LW: whole word.
  - 100 LBU: zero-extend byte[off].
  - 101 LHU: zero-extend half[off[1]].
  - Byte k = rdata[8k+7:8k].
- Errors (detected at completion, not at issue):
  - Misaligned: LH/LHU with off[0]=1, or LW with off≠0.
  - Illegal funct3 (011, 110, 111).
  - In either case: o_load=0, o_err=1 for one cycle, FSM returns to S_IDLE.
- o_pending=(state==S_WAIT_MEM). o_pending_rd=latched rd in that state, else 0. Both clear in the same cycle o_load rises for the load.
- Load issue in the same cycle as an ALU accept is allowed; the ALU write is unaffected.
- Reset mid-load: the outstanding load is discarded. A late i_mem_valid after reset is ignored (S_IDLE).

Decomposition:
- Shared CPU package holds:
  - funct3 load constants (LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101).
  - Field slice positions: RD_LSB=7, F3_LSB=12.
  - FSM state encodings.
- Sub-module load_formatter: purely combinational (funct3, offset, rdata → data, err). It is reused by a future store/load-unit bench.

Test Plan:
- ALU only: i_alu_valid, IR rd=5, result 0x1234_5678 → next cycle o_load=1, o_IR[11:7]=5, o_data=0x1234_5678; o_load=0 the cycle after.
- LB, off=3, rdata 0x80FF_0000; 3 cycles later i_mem_valid → o_data=0xFFFF_FF80, o_pending=1 during wait, o_pending_rd=rd.
- LHU, off=2, rdata 0xBEEF_0001 → o_data=0x0000_BEEF. LH on same data → 0xFFFF_BEEF.
- Collision: i_mem_valid and i_alu_valid in same cycle → o_alu_ready=0, load written first, ALU written next cycle.
- WAW: load to rd=7 pending, ALU rd=7 valid → o_alu_ready=0 until the load write cycle. ALU rd=8 is accepted immediately.
- Errors/reset:
  - LW off=1 → o_err pulse, o_load=0.
  - rd=0 ALU write → o_load=0.
  - i_rst_n low in S_WAIT_MEM → o_pending=0 immediately (async); subsequent i_mem_valid produces no write.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared CPU definitions: load funct3 codes, instruction field positions, FSM states.
package writeback_unit_pkg;

  // Instruction field positions
  localparam int unsigned RD_LSB = 7;
  localparam int unsigned F3_LSB = 12;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Writeback load-tracking states
  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StWaitMem = 1'b1
  } wb_state_e;

  // Destination register field of an instruction
  function automatic logic [4:0] get_rd(input logic [31:0] ir);
    return ir[RD_LSB +: 5];
  endfunction

  // funct3 field of an instruction
  function automatic logic [2:0] get_f3(input logic [31:0] ir);
    return ir[F3_LSB +: 3];
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: byte/half extraction and sign/zero extension
// of an aligned memory word, flagging misaligned accesses and illegal funct3.
module load_formatter
  import writeback_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and half-word out of the word
  always_comb begin
    sel_byte = rdata[7:0];
    unique case (offset)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
      default: sel_byte = rdata[7:0];
    endcase
    sel_half = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend per funct3 and detect misalignment / unsupported encodings
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{sel_byte[7]}}, sel_byte};
      F3_LH: begin
        data = {{16{sel_half[15]}}, sel_half};
        err  = offset[0];
      end
      F3_LW: begin
        data = rdata;
        err  = (offset != 2'd0);
      end
      F3_LBU: data = {24'h0, sel_byte};
      F3_LHU: begin
        data = {16'h0, sel_half};
        err  = offset[0];
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback front end: arbitrates single-cycle ALU results against
// multi-cycle load completions and drives a registered write port. Tracks a single
// outstanding load and exports its destination for decode hazard checks.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_alu_valid,
  input  logic [XLEN-1:0] i_alu_IR,
  input  logic [XLEN-1:0] i_alu_result,
  output logic            o_alu_ready,
  input  logic            i_ld_valid,
  input  logic [XLEN-1:0] i_ld_IR,
  input  logic [1:0]      i_ld_addr,
  output logic            o_ld_ready,
  input  logic            i_mem_valid,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic [XLEN-1:0] o_data,
  output logic [XLEN-1:0] o_IR,
  output logic            o_load,
  output logic            o_pending,
  output logic [4:0]      o_pending_rd,
  output logic            o_err
);

  wb_state_e       state_q, state_d;
  logic [XLEN-1:0] ld_ir_q;
  logic [1:0]      ld_off_q;

  logic [XLEN-1:0] fmt_data;
  logic            fmt_err;
  logic            ld_fire;
  logic            mem_done;
  logic            alu_fire;
  logic [4:0]      alu_rd;
  logic [4:0]      ld_rd;

  assign alu_rd = get_rd(i_alu_IR);
  assign ld_rd  = get_rd(ld_ir_q);

  load_formatter u_load_formatter (
    .funct3 (get_f3(ld_ir_q)),
    .offset (ld_off_q),
    .rdata  (i_mem_rdata),
    .data   (fmt_data),
    .err    (fmt_err)
  );

  // Next state, handshakes and pending-load export
  always_comb begin
    state_d      = state_q;
    o_ld_ready   = 1'b0;
    o_pending    = 1'b0;
    o_pending_rd = 5'd0;
    o_alu_ready  = 1'b1;
    ld_fire      = 1'b0;
    mem_done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        o_ld_ready = 1'b1;
        ld_fire    = i_ld_valid;
        if (i_ld_valid) state_d = StWaitMem;
      end
      StWaitMem: begin
        o_pending    = 1'b1;
        o_pending_rd = ld_rd;
        mem_done     = i_mem_valid;
        // Load owns the write port on completion; block ALU writes to the same rd
        // while the load is in flight so the older load cannot overwrite them.
        if (i_mem_valid || ((alu_rd == ld_rd) && (alu_rd != 5'd0))) o_alu_ready = 1'b0;
        if (i_mem_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    alu_fire = i_alu_valid && o_alu_ready;
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the issued load's instruction and byte offset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ld_ir_q  <= '0;
      ld_off_q <= 2'd0;
    end else if (ld_fire) begin
      ld_ir_q  <= i_ld_IR;
      ld_off_q <= i_ld_addr;
    end
  end

  // Registered write port; rd=0 writes are consumed but never enabled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
      o_IR   <= '0;
      o_load <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      o_err <= mem_done && fmt_err;
      if (mem_done && !fmt_err) begin
        o_data <= fmt_data;
        o_IR   <= ld_ir_q;
        o_load <= (ld_rd != 5'd0);
      end else if (alu_fire) begin
        o_data <= i_alu_result;
        o_IR   <= i_alu_IR;
        o_load <= (alu_rd != 5'd0);
      end else begin
        o_load <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: expected register-file writes are queued
// as stimulus is driven and compared in order as o_load pulses appear.
module tb_writeback_unit;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [31:0] alu_ir;
  logic [31:0] alu_result;
  logic        alu_ready;
  logic        ld_valid;
  logic [31:0] ld_ir;
  logic [1:0]  ld_addr;
  logic        ld_ready;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic [31:0] wr_data;
  logic [31:0] wr_ir;
  logic        wr_load;
  logic        pending;
  logic [4:0]  pending_rd;
  logic        err;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] ir;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  writeback_unit dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_alu_valid  (alu_valid),
    .i_alu_IR     (alu_ir),
    .i_alu_result (alu_result),
    .o_alu_ready  (alu_ready),
    .i_ld_valid   (ld_valid),
    .i_ld_IR      (ld_ir),
    .i_ld_addr    (ld_addr),
    .o_ld_ready   (ld_ready),
    .i_mem_valid  (mem_valid),
    .i_mem_rdata  (mem_rdata),
    .o_data       (wr_data),
    .o_IR         (wr_ir),
    .o_load       (wr_load),
    .o_pending    (pending),
    .o_pending_rd (pending_rd),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] rd, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {17'h0, f3, rd, opc};
  endfunction

  // Reference formatter: returns {err, data}
  function automatic logic [32:0] fmt_model(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = (off == 2'd0) ? w[7:0] : (off == 2'd1) ? w[15:8] : (off == 2'd2) ? w[23:16] : w[31:24];
    h = (off >= 2'd2) ? w[31:16] : w[15:0];
    case (f3)
      3'b000: return {1'b0, {24{b[7]}}, b};
      3'b001: return {off[0], {16{h[15]}}, h};
      3'b010: return {(off != 2'd0), w};
      3'b100: return {1'b0, 24'h0, b};
      3'b101: return {off[0], 16'h0, h};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Compare every write-port pulse against the head of the scoreboard
  always @(negedge clk) begin
    if (wr_load) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'h0, get_rd_tb(wr_ir)}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_data", wr_data, e.data);
        check("wr_ir", wr_ir, e.ir);
      end
    end
  end

  function automatic logic [4:0] get_rd_tb(input logic [31:0] ir);
    return ir[11:7];
  endfunction

  // Issue a load, hold it for wait_cycles, then return memory data and check completion
  task automatic run_load(input logic [31:0] ir, input logic [1:0] off, input logic [31:0] w,
                          input int wait_cycles, input logic exp_err,
                          input logic [31:0] exp_data);
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_ir = ir; ld_addr = off;
    @(negedge clk);
    check("ld_ready_idle", {31'h0, ld_ready}, 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge clk);
      check("pending", {31'h0, pending}, 32'd1);
      check("pending_rd", {27'h0, pending_rd}, {27'h0, ir[11:7]});
      check("ld_ready_busy", {31'h0, ld_ready}, 32'd0);
    end
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_rdata = w;
    if (!exp_err && ir[11:7] != 5'd0) exp_q.push_back('{data: exp_data, ir: ir});
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    check("pending_clear", {31'h0, pending}, 32'd0);
    check("err", {31'h0, err}, {31'h0, exp_err});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [32:0] m;
    logic [31:0] ir_a;
    rst_n = 1'b0; alu_valid = 1'b0; alu_ir = '0; alu_result = '0;
    ld_valid = 1'b0; ld_ir = '0; ld_addr = '0; mem_valid = 1'b0; mem_rdata = '0;
    #12;
    check("rst_load", {31'h0, wr_load}, 32'd0);
    check("rst_data", wr_data, 32'd0);
    check("rst_ir", wr_ir, 32'd0);
    check("rst_pending", {31'h0, pending}, 32'd0);
    check("rst_pending_rd", {27'h0, pending_rd}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    check("rst_ld_ready", {31'h0, ld_ready}, 32'd1);
    check("rst_alu_ready", {31'h0, alu_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // ALU only, one-cycle latency, single-cycle pulse
    @(posedge clk); #1;
    ir_a = mk_ir(5'd5, 3'b000, 7'b0110011);
    alu_valid = 1'b1; alu_ir = ir_a; alu_result = 32'h1234_5678;
    exp_q.push_back('{data: 32'h1234_5678, ir: ir_a});
    @(negedge clk);
    check("alu_ready_idle", {31'h0, alu_ready}, 32'd1);
    @(posedge clk); #1; alu_valid = 1'b0;
    @(negedge clk); check("alu_lat_load", {31'h0, wr_load}, 32'd1);
    @(negedge clk); check("alu_pulse_end", {31'h0, wr_load}, 32'd0);

    // Directed loads
    run_load(mk_ir(5'd9, 3'b000, 7'b0000011), 2'd3, 32'h80FF_0000, 3, 1'b0, 32'hFFFF_FF80);
    run_load(mk_ir(5'd3, 3'b101, 7'b0000011), 2'd2, 32'hBEEF_0001, 1, 1'b0, 32'h0000_BEEF);
    run_load(mk_ir(5'd4, 3'b001, 7'b0000011), 2'd2, 32'hBEEF_0001, 2, 1'b0, 32'hFFFF_BEEF);
    run_load(mk_ir(5'd6, 3'b010, 7'b0000011), 2'd1, 32'h5555_AAAA, 1, 1'b1, 32'h0);
    run_load(mk_ir(5'd6, 3'b110, 7'b0000011), 2'd0, 32'h5555_AAAA, 1, 1'b1, 32'h0);

    // Randomised loads against the reference formatter
    for (int k = 0; k < 8; k++) begin
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] w;
      logic [4:0]  rd;
      f3 = 3'($urandom_range(0, 7));
      off = 2'($urandom_range(0, 3));
      w = $urandom;
      rd = 5'($urandom_range(1, 31));
      m = fmt_model(f3, off, w);
      run_load(mk_ir(rd, f3, 7'b0000011), off, w, 1 + (k % 3), m[32], m[31:0]);
    end

    // Load issue alongside ALU accept, then completion collides with another ALU result
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_ir = mk_ir(5'd10, 3'b010, 7'b0000011); ld_addr = 2'd0;
    ir_a = mk_ir(5'd12, 3'b000, 7'b0110011);
    alu_valid = 1'b1; alu_ir = ir_a; alu_result = 32'hA5A5_0012;
    exp_q.push_back('{data: 32'hA5A5_0012, ir: ir_a});
    @(negedge clk);
    check("co_issue_alu_ready", {31'h0, alu_ready}, 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ir_a = mk_ir(5'd11, 3'b000, 7'b0110011);
    alu_ir = ir_a; alu_result = 32'h1111_2222;
    mem_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    exp_q.push_back('{data: 32'hCAFE_F00D, ir: mk_ir(5'd10, 3'b010, 7'b0000011)});
    exp_q.push_back('{data: 32'h1111_2222, ir: ir_a});
    @(negedge clk);
    check("collide_alu_ready", {31'h0, alu_ready}, 32'd0);
    @(posedge clk); #1; mem_valid = 1'b0;
    @(negedge clk);
    check("collide_after_ready", {31'h0, alu_ready}, 32'd1);
    @(posedge clk); #1; alu_valid = 1'b0;

    // WAW guard: ALU to pending rd stalls, other rd passes
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_ir = mk_ir(5'd7, 3'b100, 7'b0000011); ld_addr = 2'd1;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_ir = mk_ir(5'd7, 3'b000, 7'b0110011); alu_result = 32'h7777_0007;
    @(negedge clk); check("waw_block", {31'h0, alu_ready}, 32'd0);
    @(posedge clk); #1;
    ir_a = mk_ir(5'd8, 3'b000, 7'b0110011);
    alu_ir = ir_a; alu_result = 32'h8888_0008;
    exp_q.push_back('{data: 32'h8888_0008, ir: ir_a});
    @(negedge clk); check("waw_other_rd", {31'h0, alu_ready}, 32'd1);
    @(posedge clk); #1;
    alu_ir = mk_ir(5'd7, 3'b000, 7'b0110011); alu_result = 32'h7777_0007;
    @(negedge clk); check("waw_block2", {31'h0, alu_ready}, 32'd0);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_rdata = 32'h0000_9C00;
    exp_q.push_back('{data: 32'h0000_009C, ir: mk_ir(5'd7, 3'b100, 7'b0000011)});
    exp_q.push_back('{data: 32'h7777_0007, ir: mk_ir(5'd7, 3'b000, 7'b0110011)});
    @(negedge clk); check("waw_mem_block", {31'h0, alu_ready}, 32'd0);
    @(posedge clk); #1; mem_valid = 1'b0;
    @(negedge clk); check("waw_release", {31'h0, alu_ready}, 32'd1);
    @(posedge clk); #1; alu_valid = 1'b0;

    // rd=0 ALU write is swallowed
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_ir = mk_ir(5'd0, 3'b000, 7'b0110011); alu_result = 32'hDEAD_BEEF;
    @(negedge clk); check("rd0_ready", {31'h0, alu_ready}, 32'd1);
    @(posedge clk); #1; alu_valid = 1'b0;
    @(negedge clk); check("rd0_no_load", {31'h0, wr_load}, 32'd0);

    // Asynchronous reset mid-load discards it; late memory data is ignored
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_ir = mk_ir(5'd13, 3'b010, 7'b0000011); ld_addr = 2'd0;
    @(posedge clk); #1; ld_valid = 1'b0;
    @(negedge clk); check("pre_rst_pending", {31'h0, pending}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_pending", {31'h0, pending}, 32'd0);
    check("async_pending_rd", {27'h0, pending_rd}, 32'd0);
    check("async_ld_ready", {31'h0, ld_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; mem_valid = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(posedge clk); #1; mem_valid = 1'b0;
    @(negedge clk);
    check("late_mem_no_load", {31'h0, wr_load}, 32'd0);
    check("late_mem_no_pending", {31'h0, pending}, 32'd0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
